// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: round-robin two-port arbiter and access sequencer for a single-port data memory
module dm_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic last_q, last_d, port_q, port_d, we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic accept, win;
    // Pick the winner in IDLE (the port that did not win last time on contention) and sequence the access.
    always_comb begin
        accept = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);
        win = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        state_d = state_q;
        last_d = last_q;
        port_d = port_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = ACCESS;
                last_d = win;
                port_d = win;
                we_d = win ? req1_we : req0_we;
                addr_d = win ? req1_addr : req0_addr;
                wdata_d = win ? req1_wdata : req0_wdata;
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = we_q ? rdata_q : mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end
    // Single state register; reset leaves port 0 as the first contention winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            port_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            port_q <= port_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    assign req0_ready = accept && !win;
    assign req1_ready = accept && win;
    assign rsp0_valid = (state_q == RESP) && !port_q;
    assign rsp1_valid = (state_q == RESP) && port_q;
    assign rsp0_rdata = rdata_q;
    assign rsp1_rdata = rdata_q;
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_write = rst_n && (state_q == ACCESS) && we_q;
    assign mem_read = (state_q == ACCESS) && !we_q;
    assign busy = state_q != IDLE;
endmodule
